// File: rtl/aes_spi_responder.sv
// Serial front-end for an AES core: receives block+key MSB first, pulses the
// core, then streams the core's result back out on Miso.
module aes_spi_responder #(
  parameter int nk = 8,
  parameter int nb = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              Mosi,
  input  logic              in_valid,
  output logic              Miso,
  output logic              out_valid,
  output logic              busy,
  output logic              core_start,
  output logic [32*nb-1:0]  core_msg,
  output logic [32*nk-1:0]  core_key,
  input  logic              core_done,
  input  logic [32*nb-1:0]  core_result
);

  localparam int NB = 32 * nb;
  localparam int NK = 32 * nk;
  localparam int N  = NB + NK;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_RX = CW'(N - 1);
  localparam logic [CW-1:0] LAST_TX = CW'(NB - 1);

  typedef enum logic [2:0] {IDLE, RECV, START, WAIT, SEND} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   bit_cnt;
  logic [N-1:0]    shift_reg;
  logic [N-1:0]    shift_next;
  logic [NB-1:0]   tx_reg;

  assign shift_next = {shift_reg[N-2:0], Mosi};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Dropping cs aborts any non-idle state; core_done only matters in WAIT.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (cs) state_next = RECV;
      RECV:  if (!cs) state_next = IDLE;
             else if (in_valid && bit_cnt == LAST_RX) state_next = START;
      START: state_next = cs ? WAIT : IDLE;
      WAIT:  if (!cs) state_next = IDLE;
             else if (core_done) state_next = SEND;
      SEND:  if (!cs || bit_cnt == LAST_TX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    core_start = (state == START);
    out_valid  = (state == SEND);
    Miso       = (state == SEND) & tx_reg[NB-1];
  end

  // The counter tracks received bits in RECV and transmitted bits in SEND.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx_reg    <= '0;
      core_msg  <= '0;
      core_key  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cs && in_valid) begin
            shift_reg <= shift_next;
            bit_cnt   <= CW'(1);
          end else begin
            bit_cnt   <= '0;
          end
        end
        RECV: begin
          if (!cs) begin
            bit_cnt <= '0;
          end else if (in_valid) begin
            shift_reg <= shift_next;
            if (bit_cnt == LAST_RX) begin
              core_msg <= shift_next[N-1 -: NB];
              core_key <= shift_next[NK-1:0];
              bit_cnt  <= '0;
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
        end
        START: bit_cnt <= '0;
        WAIT: begin
          bit_cnt <= '0;
          if (cs && core_done) tx_reg <= core_result;
        end
        SEND: begin
          if (!cs || bit_cnt == LAST_TX) begin
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
          tx_reg <= {tx_reg[NB-2:0], 1'b0};
        end
        default: bit_cnt <= '0;
      endcase
    end
  end

endmodule
